// File: rtl/meas_ascii_formatter.sv
// meas_ascii_formatter: signed mV sample to fixed-width ASCII frame ("+1.234V\n") for a UART
module meas_ascii_formatter #(
  parameter int VAL_W = 14,
  parameter int DIGITS = 4,
  parameter logic [7:0] UNIT_CHAR = 8'h56
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [VAL_W-1:0]          value_i,
  input  logic                      value_valid_i,
  input  logic                      uart_busy_i,
  output logic [(DIGITS+4)*8-1:0]   char_array_o,
  output logic                      char_array_update_o,
  output logic                      busy_o,
  output logic                      ovf_o,
  output logic                      drop_o
);
  localparam int CHAR_NR = DIGITS + 4;
  localparam int BW = DIGITS * 4;
  localparam int CW = $clog2(VAL_W + 1);
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction
  localparam logic [63:0] MAX_MAG = pow10(DIGITS) - 64'd1;
  function automatic logic [7:0] digit(input logic s, input logic [3:0] n);
    return {4'h3, s ? 4'd9 : n};
  endfunction
  typedef enum logic [1:0] {IDLE, CONV, FORMAT, WAIT_TX} state_t;
  state_t state_q, state_d;
  logic [VAL_W-1:0] mag_q, mag_in;
  logic [BW-1:0] bcd_q, bcd_adj;
  logic [CW-1:0] cnt_q;
  logic sign_q, sat_q, ret_q, ovf_q, cap, upd;
  logic [CHAR_NR*8-1:0] out_q, frame;
  assign mag_in = value_i[VAL_W-1] ? -value_i : value_i;
  // ret_q marks the first IDLE cycle after a handoff, which still counts as busy
  assign busy_o = state_q != IDLE || ret_q;
  assign cap = state_q == IDLE && value_valid_i && !ret_q && !rst;
  assign drop_o = value_valid_i && busy_o && !rst;
  assign char_array_update_o = upd;
  assign char_array_o = upd ? frame : out_q;
  assign ovf_o = upd ? sat_q : ovf_q;
  always_comb begin
    state_d = state_q == IDLE   ? (cap ? CONV : IDLE) :
              state_q == CONV   ? (cnt_q == CW'(1) ? FORMAT : CONV) :
              state_q == FORMAT ? WAIT_TX :
              (uart_busy_i ? WAIT_TX : IDLE);
    upd = state_q == WAIT_TX && !uart_busy_i && !rst;
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++)
      bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] >= 4'd5 ? bcd_q[4*k +: 4] + 4'd3 : bcd_q[4*k +: 4];
    frame = '0;
    frame[8*CHAR_NR-1 -: 8] = sign_q ? 8'h2D : 8'h2B;
    frame[8*CHAR_NR-9 -: 8] = digit(sat_q, bcd_q[BW-1 -: 4]);
    frame[8*CHAR_NR-17 -: 8] = 8'h2E;
    for (int k = 0; k < DIGITS - 1; k++) frame[8*(k+2) +: 8] = digit(sat_q, bcd_q[4*k +: 4]);
    frame[15:8] = UNIT_CHAR;
    frame[7:0] = 8'h0A;
  end
  always_ff @(posedge clk) state_q <= rst ? IDLE : state_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q <= '0;
      ovf_q <= 1'b0;
      ret_q <= 1'b0;
      sign_q <= 1'b0;
      sat_q <= 1'b0;
      mag_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      ret_q <= upd;
      if (cap) begin
        sign_q <= value_i[VAL_W-1];
        mag_q <= mag_in;
        sat_q <= 64'(mag_in) > MAX_MAG;
        bcd_q <= '0;
        cnt_q <= CW'(VAL_W);
      end else if (state_q == CONV) begin
        bcd_q <= BW'({bcd_adj, mag_q[VAL_W-1]});
        mag_q <= mag_q << 1;
        cnt_q <= cnt_q - CW'(1);
      end
      if (upd) begin
        out_q <= frame;
        ovf_q <= sat_q;
      end
    end
  end
endmodule

// File: tb/tb_meas_ascii_formatter.sv
// tb_meas_ascii_formatter: directed checks of the ASCII formatter at VAL_W=14 and VAL_W=16
module tb_meas_ascii_formatter;
  logic clk = 1'b0, rst = 1'b1, ub = 1'b0;
  logic [13:0] v14 = '0;
  logic [15:0] v16 = '0;
  logic vv14 = 1'b0, vv16 = 1'b0;
  logic [63:0] ca14, ca16;
  logic up14, up16, bz14, bz16, ov14, ov16, dr14, dr16;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  meas_ascii_formatter #(.VAL_W(14)) d14 (
    .clk(clk), .rst(rst), .value_i(v14), .value_valid_i(vv14), .uart_busy_i(ub),
    .char_array_o(ca14), .char_array_update_o(up14), .busy_o(bz14), .ovf_o(ov14), .drop_o(dr14));
  meas_ascii_formatter #(.VAL_W(16)) d16 (
    .clk(clk), .rst(rst), .value_i(v16), .value_valid_i(vv16), .uart_busy_i(ub),
    .char_array_o(ca16), .char_array_update_o(up16), .busy_o(bz16), .ovf_o(ov16), .drop_o(dr16));
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // strobe a sample, wait for the update pulse, check frame/ovf/latency, then the pulse and busy tail
  task automatic xfer(input bit wide, input int val, input logic [63:0] exp,
                      input logic eovf, input int elat, input string tag);
    int n;
    if (wide) begin v16 = 16'(val); vv16 = 1'b1; end
    else begin v14 = 14'(val); vv14 = 1'b1; end
    step();
    vv14 = 1'b0;
    vv16 = 1'b0;
    n = 1;
    while (!(wide ? up16 : up14) && n < 60) begin step(); n++; end
    chk({tag, "_lat"}, 64'(n), 64'(elat));
    chk({tag, "_frame"}, wide ? ca16 : ca14, exp);
    chk({tag, "_ovf"}, 64'(wide ? ov16 : ov14), 64'(eovf));
    step();
    chk({tag, "_pulse1"}, 64'(wide ? up16 : up14), 64'd0);
    chk({tag, "_retbusy"}, 64'(wide ? bz16 : bz14), 64'd1);
    step();
    chk({tag, "_idle"}, 64'(wide ? bz16 : bz14), 64'd0);
  endtask
  initial begin
    int n;
    logic early, moved;
    step();
    step();
    rst = 1'b0;
    chk("rst_frame", ca14, 64'd0);
    chk("rst_upd", 64'(up14), 64'd0);
    chk("rst_busy", 64'(bz14), 64'd0);
    chk("rst_ovf", 64'(ov14), 64'd0);
    chk("rst_drop", 64'(dr14), 64'd0);
    xfer(0, 1234, 64'h2B312E323334560A, 1'b0, 16, "p1234");
    xfer(0, -5, 64'h2D302E303035560A, 1'b0, 16, "m5");
    xfer(0, -8192, 64'h2D382E313932560A, 1'b0, 16, "m8192");
    xfer(0, 0, 64'h2B302E303030560A, 1'b0, 16, "zero");
    chk("stable_after", ca14, 64'h2B302E303030560A);
    xfer(1, 12000, 64'h2B392E393939560A, 1'b1, 18, "sat12000");
    chk("ovf_held", 64'(ov16), 64'd1);
    xfer(1, 7, 64'h2B302E303037560A, 1'b0, 18, "p7_16");
    // UART busy for cycles 0..40, released in cycle 41
    ub = 1'b1;
    v14 = 14'd500;
    vv14 = 1'b1;
    early = 1'b0;
    moved = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      vv14 = 1'b0;
      early |= up14;
      moved |= ca14 !== 64'h2B302E303030560A;
    end
    chk("ub_no_early", 64'(early), 64'd0);
    chk("ub_hold_frame", 64'(moved), 64'd0);
    chk("ub_still_busy", 64'(bz14), 64'd1);
    step();
    ub = 1'b0;
    #1;
    chk("ub_pulse", 64'(up14), 64'd1);
    chk("ub_frame", ca14, 64'h2B302E353030560A);
    step();
    step();
    // drop: second strobe in cycle 5 of the first conversion
    v14 = 14'd100;
    vv14 = 1'b1;
    step();
    vv14 = 1'b0;
    for (int i = 0; i < 4; i++) step();
    v14 = 14'd200;
    vv14 = 1'b1;
    #1;
    chk("drop_pulse", 64'(dr14), 64'd1);
    step();
    vv14 = 1'b0;
    #1;
    chk("drop_once", 64'(dr14), 64'd0);
    n = 6;
    while (!up14 && n < 60) begin step(); n++; end
    chk("drop_lat", 64'(n), 64'd16);
    chk("drop_frame", ca14, 64'h2B302E313030560A);
    step();
    vv14 = 1'b1;
    #1;
    chk("drop_ret_cycle", 64'(dr14), 64'd1);
    step();
    vv14 = 1'b0;
    xfer(0, 200, 64'h2B302E323030560A, 1'b0, 16, "after_drop");
    // reset in cycle 8 of a conversion
    v14 = 14'd3000;
    vv14 = 1'b1;
    step();
    vv14 = 1'b0;
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("ar_frame", ca14, 64'd0);
    chk("ar_busy", 64'(bz14), 64'd0);
    chk("ar_ovf", 64'(ov14), 64'd0);
    early = 1'b0;
    for (int i = 0; i < 20; i++) begin step(); early |= up14; end
    chk("ar_no_pulse", 64'(early), 64'd0);
    xfer(0, 42, 64'h2B302E303432560A, 1'b0, 16, "p42");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
